// File: rtl/delay_memory_pkg.sv
// Shared constants for the delay-path memory responder: CSR map, FSM encoding, widths.
package delay_memory_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned CSR_AW = 3;

  localparam logic [CSR_AW-1:0] LAT_OFF   = 3'd0;
  localparam logic [CSR_AW-1:0] RDCNT_OFF = 3'd1;
  localparam logic [CSR_AW-1:0] WRCNT_OFF = 3'd2;
  localparam logic [CSR_AW-1:0] CLR_OFF   = 3'd3;

  localparam logic [DATA_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/delay_memory_responder_if.sv
// Avalon-MM slave bus between the delay path (master) and the responder (slave).
interface delay_memory_responder_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [ADDR_W-1:0] s_address;
  logic [3:0]        s_byteenable;
  logic              s_chipselect;
  logic              s_clken;
  logic              s_read;
  logic              s_write;
  logic [31:0]       s_writedata;
  logic [31:0]       s_readdata;
  logic              s_waitrequest;

  modport master (
    output s_address, s_byteenable, s_chipselect, s_clken, s_read, s_write, s_writedata,
    input  s_readdata, s_waitrequest
  );

  modport slave (
    input  s_address, s_byteenable, s_chipselect, s_clken, s_read, s_write, s_writedata,
    output s_readdata, s_waitrequest
  );
endinterface

// File: rtl/delay_memory_responder_be_ram_sp.sv
// Single-port 32-bit RAM with per-byte write enables and a registered, resettable read port.
module be_ram_sp
  import delay_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [BE_W-1:0]          be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register holds its value until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_memory_responder.sv
// Avalon-MM memory model with programmable waitrequest latency and read/write counters on a CSR port.
module delay_memory_responder
  import delay_memory_pkg::*;
#(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LAT_RESET = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CSR_AW-1:0]    csr_address,
  input  logic                 csr_write,
  input  logic [DATA_W-1:0]    csr_writedata,
  input  logic                 csr_read,
  output logic [DATA_W-1:0]    csr_readdata,
  delay_memory_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q;
  logic [DATA_W-1:0] rd_cnt_q, wr_cnt_q;

  logic req_c, commit_c, ram_we_c, rd_load_c;
  logic clr_c, lat_we_c, rd_inc_c, wr_inc_c;
  logic unused_c;

  assign req_c = bus.s_chipselect & (bus.s_read | bus.s_write);

  // Stall everything except the single ACK cycle of an active request.
  assign bus.s_waitrequest = req_c & (state_q != ST_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a dropped request aborts regardless of clock enable.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c && bus.s_clken) begin
          cnt_d   = lat_q;
          state_d = (lat_q != '0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (bus.s_clken) begin
          cnt_d = cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (bus.s_clken) begin
          state_d  = ST_IDLE;
          commit_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads sample the array on the edge entering ACK; simultaneous read+write counts as a write.
  assign rd_load_c = (state_d == ST_ACK) && (state_q != ST_ACK) && !bus.s_write;
  assign ram_we_c  = commit_c & bus.s_write;
  assign rd_inc_c  = commit_c & ~bus.s_write;
  assign wr_inc_c  = commit_c & bus.s_write;

  assign clr_c    = csr_write && (csr_address == CLR_OFF);
  assign lat_we_c = csr_write && (csr_address == LAT_OFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= LAT_W'(LAT_RESET);
    end else if (lat_we_c) begin
      lat_q <= csr_writedata[LAT_W-1:0];
    end
  end

  // Saturating counters; CLEAR beats a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (clr_c) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_inc_c && (rd_cnt_q != CNT_MAX)) rd_cnt_q <= rd_cnt_q + DATA_W'(1);
      if (wr_inc_c && (wr_cnt_q != CNT_MAX)) wr_cnt_q <= wr_cnt_q + DATA_W'(1);
    end
  end

  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      LAT_OFF:   csr_readdata = DATA_W'(lat_q);
      RDCNT_OFF: csr_readdata = rd_cnt_q;
      WRCNT_OFF: csr_readdata = wr_cnt_q;
      default:   csr_readdata = '0;
    endcase
  end

  // Upper address bits alias; CSR reads are side-effect free.
  assign unused_c = ^{csr_read, csr_writedata[DATA_W-1:LAT_W], bus.s_address[ADDR_W-1:IDX_W]};

  be_ram_sp #(
    .DEPTH (MEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we_c),
    .be_i    (bus.s_byteenable),
    .addr_i  (bus.s_address[IDX_W-1:0]),
    .wdata_i (bus.s_writedata),
    .re_i    (rd_load_c),
    .rdata_o (bus.s_readdata)
  );

endmodule

// File: tb/tb_delay_memory_responder.sv
// Scoreboard bench: drivers queue expected waitrequest lengths, read data and CSR values; a monitor checks them.
module tb_delay_memory_responder;

  localparam int unsigned ADDR_W    = 23;
  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;

  delay_memory_responder_if #(.ADDR_W(ADDR_W)) bus ();

  delay_memory_responder #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS),
    .LAT_RESET (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int          exp_hi_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_csr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts stall cycles per request and checks at ACK; checks CSR reads when strobed.
  int   hi_cnt = 0;
  logic req_s;
  always @(negedge clk) begin
    if (csr_read) begin
      if (exp_csr_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL csr_unexpected: got 0x%08h at addr %0d, expected no read", csr_readdata, csr_address);
      end else begin
        chk($sformatf("csr[%0d]", csr_address), csr_readdata, exp_csr_q.pop_front());
      end
    end
    req_s = bus.s_chipselect & (bus.s_read | bus.s_write);
    if (reset || !req_s) begin
      hi_cnt = 0;
    end else if (bus.s_waitrequest) begin
      hi_cnt++;
    end else begin
      if (exp_hi_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ack_unexpected: got ACK after %0d stall cycles, expected none", hi_cnt);
      end else begin
        chk("wait_cycles", 32'(hi_cnt), 32'(exp_hi_q.pop_front()));
      end
      if (bus.s_read && !bus.s_write) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.s_readdata);
        end else begin
          chk("readdata", bus.s_readdata, exp_rd_q.pop_front());
        end
      end
      hi_cnt = 0;
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    tick();
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_chk(input logic [2:0] a, input logic [31:0] exp);
    tick();
    csr_address = a; csr_read = 1'b1;
    exp_csr_q.push_back(exp);
    tick();
    csr_read = 1'b0;
  endtask

  // One complete access; s_clken is held low for stall_len cycles starting at cycle stall_at.
  task automatic access(input bit wr, input logic [22:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input int exp_hi, input logic [31:0] exp_rd,
                        input int stall_at, input int stall_len);
    int cyc;
    cyc = 0;
    tick();
    bus.s_chipselect = 1'b1; bus.s_read = !wr; bus.s_write = wr;
    bus.s_address = addr; bus.s_byteenable = be; bus.s_writedata = data;
    exp_hi_q.push_back(exp_hi);
    if (!wr) exp_rd_q.push_back(exp_rd);
    forever begin
      bus.s_clken = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (!bus.s_waitrequest) break;
      cyc++;
      if (cyc > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL access_timeout: got no ACK after %0d cycles, expected %0d", cyc, exp_hi);
        break;
      end
      tick();
    end
    tick();
    bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_clken = 1'b1;
  endtask

  task automatic wr_acc(input logic [22:0] a, input logic [3:0] be, input logic [31:0] d, input int hi);
    access(1'b1, a, be, d, hi, 32'h0, 0, 0);
  endtask

  task automatic rd_acc(input logic [22:0] a, input logic [31:0] exp, input int hi);
    access(1'b0, a, 4'hF, 32'h0, hi, exp, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    csr_address = '0; csr_write = 1'b0; csr_writedata = '0; csr_read = 1'b0;
    bus.s_address = '0; bus.s_byteenable = '0; bus.s_chipselect = 1'b0; bus.s_clken = 1'b1;
    bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_writedata = '0;
    repeat (2) tick();
    bus.s_chipselect = 1'b1; bus.s_read = 1'b1;
    @(negedge clk);
    chk("wreq_in_reset", 32'(bus.s_waitrequest), 32'd1);
    chk("rdata_reset", bus.s_readdata, 32'h0);
    tick();
    bus.s_chipselect = 1'b0; bus.s_read = 1'b0;
    reset = 1'b0;

    csr_chk(3'd0, 32'd0);
    csr_chk(3'd1, 32'd0);
    csr_chk(3'd2, 32'd0);
    csr_chk(3'd5, 32'd0);

    // Zero latency write/read.
    wr_acc(23'd5, 4'hF, 32'hDEADBEEF, 1);
    rd_acc(23'd5, 32'hDEADBEEF, 1);
    csr_chk(3'd1, 32'd1);
    csr_chk(3'd2, 32'd1);

    // Latency register width, then a mid-access latency change.
    csr_wr(3'd0, 32'h0000_01FF);
    csr_chk(3'd0, 32'h0000_00FF);
    csr_wr(3'd0, 32'd3);
    csr_chk(3'd0, 32'd3);
    fork
      rd_acc(23'd5, 32'hDEADBEEF, 4);
      begin tick(); tick(); csr_wr(3'd0, 32'd7); end
    join
    csr_chk(3'd0, 32'd7);
    rd_acc(23'd5, 32'hDEADBEEF, 8);

    // Byte lanes and address aliasing.
    csr_wr(3'd0, 32'd0);
    wr_acc(23'd2, 4'hF, 32'h11223344, 1);
    wr_acc(23'd2, 4'b0101, 32'hAABBCCDD, 1);
    rd_acc(23'd2, 32'h11BB33DD, 1);
    rd_acc(23'd2 + 23'(MEM_WORDS), 32'h11BB33DD, 1);
    csr_chk(3'd2, 32'd3);
    csr_chk(3'd1, 32'd5);

    // Clock-enable freeze in WAIT, then an aborted write.
    csr_wr(3'd0, 32'd5);
    access(1'b0, 23'd2, 4'hF, 32'h0, 9, 32'h11BB33DD, 2, 3);
    tick();
    bus.s_chipselect = 1'b1; bus.s_write = 1'b1; bus.s_address = 23'd2;
    bus.s_byteenable = 4'hF; bus.s_writedata = 32'h0;
    repeat (3) tick();
    bus.s_chipselect = 1'b0; bus.s_write = 1'b0;
    csr_wr(3'd0, 32'd0);
    rd_acc(23'd2, 32'h11BB33DD, 1);
    csr_chk(3'd1, 32'd7);
    csr_chk(3'd2, 32'd3);
    csr_wr(3'd6, 32'h55);
    csr_chk(3'd0, 32'd0);
    csr_chk(3'd3, 32'd0);
    csr_chk(3'd6, 32'd0);

    // Read counter saturation, then CLEAR coinciding with an ACK.
    force dut.rd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.rd_cnt_q;
    rd_acc(23'd2, 32'h11BB33DD, 1);
    rd_acc(23'd2, 32'h11BB33DD, 1);
    csr_chk(3'd1, 32'hFFFF_FFFF);
    tick();
    bus.s_chipselect = 1'b1; bus.s_read = 1'b1; bus.s_address = 23'd2;
    exp_hi_q.push_back(1);
    exp_rd_q.push_back(32'h11BB33DD);
    tick();
    csr_address = 3'd3; csr_writedata = 32'h1; csr_write = 1'b1;
    tick();
    csr_write = 1'b0; bus.s_chipselect = 1'b0; bus.s_read = 1'b0;
    csr_chk(3'd1, 32'd0);
    csr_chk(3'd2, 32'd0);

    // Reset in the middle of a write.
    wr_acc(23'd9, 4'hF, 32'h12345678, 1);
    csr_chk(3'd2, 32'd1);
    csr_wr(3'd0, 32'd6);
    tick();
    bus.s_chipselect = 1'b1; bus.s_write = 1'b1; bus.s_address = 23'd9;
    bus.s_byteenable = 4'hF; bus.s_writedata = 32'hFFFF_FFFF;
    repeat (3) tick();
    reset = 1'b1; bus.s_chipselect = 1'b0; bus.s_write = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rdata_after_reset", bus.s_readdata, 32'h0);
    csr_chk(3'd0, 32'd0);
    csr_chk(3'd1, 32'd0);
    csr_chk(3'd2, 32'd0);
    rd_acc(23'd9, 32'h12345678, 1);

    repeat (3) tick();
    chk("pending_acks", 32'(exp_hi_q.size()), 32'd0);
    chk("pending_reads", 32'(exp_rd_q.size()), 32'd0);
    chk("pending_csr", 32'(exp_csr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
